sequence_detect_param: RTL and testbench
========================================

Name: sequence_detect_param

Overview:
Parametrised serial bit-pattern detector, the successor to the fixed 8-bit detector. Shifts a 1-bit stream qualified by in_valid into a SEQ_W-bit history and compares it against a runtime-loadable pattern with a per-bit compare mask. Overlap and non-overlap modes are selectable at runtime. Provides a one-cycle match pulse and a saturating match counter for control/monitor logic in the stream datapath.

Parameters:
SEQ_W, 8, pattern/history length in bits (2..32)
CNT_W, 16, width of saturating match counter

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous active-high reset
cfg_load  input  1  pulse: capture cfg_pattern/cfg_mask/cfg_overlap, restart detection
cfg_pattern  input  SEQ_W  target sequence; bit 0 = most recent bit
cfg_mask  input  SEQ_W  1 = compare bit, 0 = don't care
cfg_overlap  input  1  1 = overlapping matches allowed, 0 = non-overlapping
cnt_clr  input  1  pulse: clear match_cnt
in_valid  input  1  in_data is a valid stream bit this cycle
in_data  input  1  serial stream bit
match  output  1  one-cycle pulse, sequence completed by previous accepted beat
armed  output  1  history holds SEQ_W valid bits since last restart
match_cnt  output  CNT_W  saturating count of matches

Behaviour:
- Synchronous reset only. Reset values: match=0, armed=0, match_cnt=0, history=0, fill=0, pat_r=0, mask_r=all ones, ovl_r=1.
- Config shadow regs pat_r/mask_r/ovl_r update only on cfg_load; cfg_* ignored otherwise.
- Beat accepted when in_valid=1 and cfg_load=0. On accept: hist_next = {hist[SEQ_W-2:0], in_data}; fill increments, saturating at SEQ_W.
- hit = accept && (fill_next == SEQ_W) && (((hist_next ^ pat_r) & mask_r) == 0).
- match registered: match = hit of the previous cycle. Latency 1 cycle from the accepting edge; pulse width exactly 1 cycle. No match while in_valid=0.
- armed = (fill == SEQ_W), registered.
- Overlap (ovl_r=1): history and fill kept after a hit; next match possible on the very next beat.
- Non-overlap (ovl_r=0): on a hit, history cleared to 0 and fill to 0 in the same edge. The next match needs SEQ_W fresh beats.
- Restart (cfg_load=1): history=0, fill=0, armed=0, match=0 next cycle. Any in_valid beat that cycle is discarded. match_cnt unaffected.
- Gating: no match before SEQ_W beats since reset/restart. This applies even if the zero-filled history would compare equal.
- mask_r=0: every accepted beat after arming matches.
- match_cnt: +1 on each hit, saturates at 2^CNT_W-1 (no wrap). cnt_clr forces 0 and wins over a simultaneous hit.
- Reset mid-stream: all state to reset values on that edge; partial sequences discarded.
- Priority per edge: rst > cfg_load > beat accept.

Test Plan:
- Basic (SEQ_W=8, load pat=0x71, mask=0xFF, ovl=1): beats 0,1,1,1,0,0,0,1 on consecutive cycles -> match high exactly 1 cycle after the 8th beat edge, match_cnt=1, armed=1 from the cycle after the 8th beat.
- Overlap vs non-overlap (pat=0xAA): stream 1,0 repeated for 12 beats -> ovl=1: matches after beats 8,10,12, cnt=3; ovl=0: single match after beat 8, then next possible only at beat 16.
- Fill gating after reset (pat=0x00, mask=0xFF): 7 zeros -> no match, armed=0; 8th zero -> match pulse; with ovl=1 a 9th zero -> match again, cnt=2.
- Valid gaps and mask (pat=0x70, mask=0xF0): beats 0,1,1,1,x,x,x,x with random in_valid=0 idle cycles between them -> one match, 1 cycle after the 8th valid beat; no shift during idle cycles.
- Saturation/clear (CNT_W=2): 5 matches -> match_cnt stays 3. cnt_clr asserted in the same cycle as a hit -> match_cnt=0, match still pulses.
- Restart/reset mid-operation: cfg_load with in_valid=1 after 5 beats -> beat dropped, armed=0; 8 new beats needed for a match. rst asserted mid-stream -> match=0, cnt=0, mask_r=0xFF, next match only after 8 post-reset beats.

Source files
------------

// File: rtl/sequence_detect_param.sv
// Parametrised serial pattern detector: SEQ_W-bit history compared against a
// runtime pattern/mask, with overlap control, a match pulse and a saturating match count.
module sequence_detect_param #(
  parameter int SEQ_W = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_load,
  input  logic [SEQ_W-1:0] cfg_pattern,
  input  logic [SEQ_W-1:0] cfg_mask,
  input  logic             cfg_overlap,
  input  logic             cnt_clr,
  input  logic             in_valid,
  input  logic             in_data,
  output logic             match,
  output logic             armed,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int                FILL_W    = $clog2(SEQ_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(SEQ_W);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  logic [SEQ_W-1:0]  hist_r;
  logic [FILL_W-1:0] fill_r;
  logic [SEQ_W-1:0]  pat_r;
  logic [SEQ_W-1:0]  mask_r;
  logic              ovl_r;

  logic              accept_s;
  logic [SEQ_W-1:0]  shift_s;
  logic [FILL_W-1:0] fill_inc_s;
  logic              hit_s;
  logic [SEQ_W-1:0]  hist_d_s;
  logic [FILL_W-1:0] fill_d_s;

  // Next history/fill and hit decision; restart beats shifting, a non-overlap hit clears.
  always_comb begin
    accept_s = in_valid & ~cfg_load;
    shift_s  = {hist_r[SEQ_W-2:0], in_data};
    if (fill_r == FILL_FULL) begin
      fill_inc_s = fill_r;
    end else begin
      fill_inc_s = fill_r + FILL_W'(1);
    end
    hit_s = accept_s && (fill_inc_s == FILL_FULL) &&
            (((shift_s ^ pat_r) & mask_r) == {SEQ_W{1'b0}});
    hist_d_s = hist_r;
    fill_d_s = fill_r;
    if (cfg_load) begin
      hist_d_s = {SEQ_W{1'b0}};
      fill_d_s = {FILL_W{1'b0}};
    end else if (hit_s && !ovl_r) begin
      hist_d_s = {SEQ_W{1'b0}};
      fill_d_s = {FILL_W{1'b0}};
    end else if (accept_s) begin
      hist_d_s = shift_s;
      fill_d_s = fill_inc_s;
    end else begin
      hist_d_s = hist_r;
      fill_d_s = fill_r;
    end
  end

  // State, configuration shadow and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      hist_r    <= {SEQ_W{1'b0}};
      fill_r    <= {FILL_W{1'b0}};
      pat_r     <= {SEQ_W{1'b0}};
      mask_r    <= {SEQ_W{1'b1}};
      ovl_r     <= 1'b1;
      match     <= 1'b0;
      armed     <= 1'b0;
      match_cnt <= {CNT_W{1'b0}};
    end else begin
      hist_r <= hist_d_s;
      fill_r <= fill_d_s;
      match  <= hit_s;
      armed  <= (fill_d_s == FILL_FULL);
      if (cfg_load) begin
        pat_r  <= cfg_pattern;
        mask_r <= cfg_mask;
        ovl_r  <= cfg_overlap;
      end else begin
        pat_r  <= pat_r;
        mask_r <= mask_r;
        ovl_r  <= ovl_r;
      end
      // Clear wins over a coincident hit; the count holds at its maximum.
      if (cnt_clr) begin
        match_cnt <= {CNT_W{1'b0}};
      end else if (hit_s && (match_cnt != CNT_MAX)) begin
        match_cnt <= match_cnt + CNT_W'(1);
      end else begin
        match_cnt <= match_cnt;
      end
    end
  end

endmodule

// File: tb/tb_sequence_detect_param.sv
// Directed bench for sequence_detect_param: bit-queue reference model checked
// every cycle, plus literal expectations at the key points of each scenario.
module tb_sequence_detect_param;

  localparam int SEQ_W = 8;
  localparam int CNT_W = 2;
  localparam int CNT_SAT = 3;

  logic             clk = 1'b0;
  logic             rst, cfg_load, cfg_overlap, cnt_clr, in_valid, in_data;
  logic [SEQ_W-1:0] cfg_pattern, cfg_mask;
  logic             match, armed;
  logic [CNT_W-1:0] match_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  sequence_detect_param #(.SEQ_W(SEQ_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
    .cfg_mask(cfg_mask), .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr),
    .in_valid(in_valid), .in_data(in_data),
    .match(match), .armed(armed), .match_cnt(match_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: a queue of accepted bits since the last restart.
  logic             q[$];
  logic [SEQ_W-1:0] m_pat, m_mask;
  logic             m_ovl;
  logic             m_match;
  int               m_cnt;
  bit               model_en = 1'b0;

  always @(posedge clk) begin
    logic [SEQ_W-1:0] win;
    bit               hit;
    hit = 1'b0;
    if (rst) begin
      q.delete();
      m_pat = '0; m_mask = '1; m_ovl = 1'b1; m_cnt = 0;
    end else if (cfg_load) begin
      q.delete();
      m_pat = cfg_pattern; m_mask = cfg_mask; m_ovl = cfg_overlap;
    end else if (in_valid) begin
      q.push_back(in_data);
      if (q.size() > SEQ_W) void'(q.pop_front());
      if (q.size() == SEQ_W) begin
        hit = 1'b1;
        for (int i = 0; i < SEQ_W; i++) begin
          win[i] = q[SEQ_W-1-i];
          if (m_mask[i] && (win[i] != m_pat[i])) hit = 1'b0;
        end
        if (hit && !m_ovl) q.delete();
      end
    end
    if (!rst) begin
      if (cnt_clr) m_cnt = 0;
      else if (hit && m_cnt < CNT_SAT) m_cnt++;
    end
    m_match = hit;
  end

  // Compare DUT against the model away from the active edge.
  always @(negedge clk) begin
    if (model_en) begin
      check("model_match", 32'(match), 32'(m_match));
      check("model_armed", 32'(armed), 32'(q.size() == SEQ_W));
      check("model_cnt",   32'(match_cnt), 32'(m_cnt));
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic beat(input logic b);
    in_valid = 1'b1; in_data = b;
    tick();
    in_valid = 1'b0; in_data = 1'b0;
  endtask

  task automatic load(input logic [7:0] p, input logic [7:0] m, input logic o);
    cfg_load = 1'b1; cfg_pattern = p; cfg_mask = m; cfg_overlap = o;
    tick();
    cfg_load = 1'b0; cfg_pattern = '0; cfg_mask = '0; cfg_overlap = 1'b0;
  endtask

  task automatic clear_cnt();
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
  endtask

  task automatic beats8(input logic [7:0] seq);
    for (int i = 7; i >= 0; i--) beat(seq[i]);
  endtask

  initial begin
    int tally;
    rst = 1'b1; cfg_load = 1'b0; cfg_pattern = '0; cfg_mask = '0; cfg_overlap = 1'b0;
    cnt_clr = 1'b0; in_valid = 1'b0; in_data = 1'b0;
    tick(); tick();
    model_en = 1'b1;
    rst = 1'b0;
    check("reset_match", 32'(match), 32'd0);
    check("reset_armed", 32'(armed), 32'd0);
    check("reset_cnt", 32'(match_cnt), 32'd0);

    // Basic detection of 0x71
    load(8'h71, 8'hFF, 1'b1);
    for (int i = 7; i >= 1; i--) beat(logic'((8'h71 >> i) & 8'h01));
    check("basic_armed_b7", 32'(armed), 32'd0);
    check("basic_match_b7", 32'(match), 32'd0);
    beat(1'b1);
    check("basic_match", 32'(match), 32'd1);
    check("basic_armed", 32'(armed), 32'd1);
    check("basic_cnt", 32'(match_cnt), 32'd1);
    tick();
    check("basic_pulse_width", 32'(match), 32'd0);

    // Overlapping 1,0 stream
    clear_cnt();
    load(8'hAA, 8'hFF, 1'b1);
    tally = 0;
    for (int i = 0; i < 12; i++) begin beat(logic'(i % 2 == 0)); tally += int'(match); end
    check("ovl_matches", 32'(tally), 32'd3);
    check("ovl_cnt", 32'(match_cnt), 32'd3);

    // Non-overlapping 1,0 stream
    clear_cnt();
    load(8'hAA, 8'hFF, 1'b0);
    tally = 0;
    for (int i = 0; i < 12; i++) begin beat(logic'(i % 2 == 0)); tally += int'(match); end
    check("novl_matches12", 32'(tally), 32'd1);
    for (int i = 12; i < 16; i++) beat(logic'(i % 2 == 0));
    check("novl_match16", 32'(match), 32'd1);
    check("novl_cnt", 32'(match_cnt), 32'd2);

    // Masked pattern with idle gaps between valid beats
    clear_cnt();
    load(8'h70, 8'hF0, 1'b1);
    tally = 0;
    for (int i = 7; i >= 0; i--) begin
      beat((i >= 4) ? logic'((8'h70 >> i) & 8'h01) : logic'($urandom_range(0, 1)));
      if (i > 0) begin
        tally += int'(match);
        repeat ($urandom_range(0, 3)) begin tick(); tally += int'(match); end
      end
    end
    check("gap_no_early", 32'(tally), 32'd0);
    check("gap_match", 32'(match), 32'd1);
    check("gap_cnt", 32'(match_cnt), 32'd1);

    // Mid-stream reset, then zero-pattern gating on reset defaults
    for (int i = 0; i < 5; i++) beat(1'b0);
    rst = 1'b1; in_valid = 1'b1; in_data = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0; in_data = 1'b0;
    check("rst_match", 32'(match), 32'd0);
    check("rst_cnt", 32'(match_cnt), 32'd0);
    check("rst_armed", 32'(armed), 32'd0);
    beats8(8'h01);
    check("rst_mask_full", 32'(match), 32'd0);
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < 7; i++) beat(1'b0);
    check("gate_armed7", 32'(armed), 32'd0);
    check("gate_match7", 32'(match), 32'd0);
    beat(1'b0);
    check("gate_match8", 32'(match), 32'd1);
    beat(1'b0);
    check("gate_match9", 32'(match), 32'd1);
    check("gate_cnt", 32'(match_cnt), 32'd2);

    // Saturation with an all-don't-care mask, then clear against a hit
    clear_cnt();
    load(8'h00, 8'h00, 1'b1);
    for (int i = 0; i < 12; i++) beat(logic'($urandom_range(0, 1)));
    check("sat_cnt", 32'(match_cnt), 32'd3);
    cnt_clr = 1'b1;
    beat(1'b1);
    cnt_clr = 1'b0;
    check("clr_hit_match", 32'(match), 32'd1);
    check("clr_hit_cnt", 32'(match_cnt), 32'd0);
    beat(1'b0);
    check("after_clr_cnt", 32'(match_cnt), 32'd1);

    // Restart mid-sequence drops the coincident beat
    clear_cnt();
    load(8'h71, 8'hFF, 1'b1);
    for (int i = 7; i >= 3; i--) beat(logic'((8'h71 >> i) & 8'h01));
    cfg_pattern = 8'h71; cfg_mask = 8'hFF; cfg_overlap = 1'b1;
    cfg_load = 1'b1; in_valid = 1'b1; in_data = 1'b0;
    tick();
    cfg_load = 1'b0; in_valid = 1'b0;
    check("restart_armed", 32'(armed), 32'd0);
    check("restart_match", 32'(match), 32'd0);
    tally = 0;
    for (int i = 7; i >= 1; i--) begin beat(logic'((8'h71 >> i) & 8'h01)); tally += int'(match); end
    check("restart_no_early", 32'(tally), 32'd0);
    beat(1'b1);
    check("restart_match8", 32'(match), 32'd1);
    check("restart_cnt", 32'(match_cnt), 32'd1);

    tick(); tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
